// File: rtl/gshare_bp.sv
// gshare branch direction predictor.
// Predicts at IF with a combinational lookup of a PHT indexed by PC xor global history.
// Training comes from ID, using the index and history snapshot that travelled with the branch.
// After reset the table is swept to weakly-not-taken, one entry per cycle.
// Ports:
//   CLK, RST_X            clock (rising edge), asynchronous active-high reset
//   ready                 table initialised; predictions and updates accepted
//   pred_valid, pred_pc   IF prediction request
//   pred_taken            predicted direction (combinational)
//   pred_idx, pred_hist   PHT index and pre-shift history, carried down the pipe
//   upd_valid, upd_idx, upd_hist, upd_taken, upd_mispred   resolved-branch training
//   ghr                   current speculative global history
//   stat_pred, stat_miss  saturating counts of predictions and mispredicts
module gshare_bp #(
   parameter int unsigned IDX_W  = 14,
   parameter int unsigned HIST_W = 14,
   parameter int unsigned CTR_W  = 2,
   parameter int unsigned PC_LSB = 2
) (
   input  logic              CLK,
   input  logic              RST_X,
   output logic              ready,
   input  logic              pred_valid,
   input  logic [31:0]       pred_pc,
   output logic              pred_taken,
   output logic [IDX_W-1:0]  pred_idx,
   output logic [HIST_W-1:0] pred_hist,
   input  logic              upd_valid,
   input  logic [IDX_W-1:0]  upd_idx,
   input  logic [HIST_W-1:0] upd_hist,
   input  logic              upd_taken,
   input  logic              upd_mispred,
   output logic [HIST_W-1:0] ghr,
   output logic [31:0]       stat_pred,
   output logic [31:0]       stat_miss
);

   localparam int unsigned DEPTH = 1 << IDX_W;
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

   typedef enum logic {StInit, StRun} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [HIST_W-1:0] ghr_q, ghr_d;
   logic [31:0]       stat_pred_q, stat_pred_d;
   logic [31:0]       stat_miss_q, stat_miss_d;

   logic [CTR_W-1:0]  pht [DEPTH];

   logic              pht_we;
   logic [IDX_W-1:0]  pht_waddr;
   logic [CTR_W-1:0]  pht_wdata;
   logic [CTR_W-1:0]  upd_old;
   logic [IDX_W-1:0]  ghr_ext;
   logic              run;
   logic              repair;

   // Only the hashed PC field and the low HIST_W-1 history bits are consumed.
   logic unused_inputs;
   assign unused_inputs = ^{pred_pc, upd_hist[HIST_W-1]};

   assign run   = (state_q == StRun);
   assign ready = run;

   always_comb begin
      ghr_ext = '0;
      ghr_ext[HIST_W-1:0] = ghr_q;
   end

   assign pred_idx   = pred_pc[PC_LSB+IDX_W-1:PC_LSB] ^ ghr_ext;
   assign pred_hist  = ghr_q;
   assign pred_taken = run & pred_valid & pht[pred_idx][CTR_W-1];

   assign ghr       = ghr_q;
   assign stat_pred = stat_pred_q;
   assign stat_miss = stat_miss_q;

   assign repair  = upd_valid & upd_mispred;
   assign upd_old = pht[upd_idx];

   // Init sweep and training share a single table write port.
   always_comb begin
      pht_we    = 1'b0;
      pht_waddr = upd_idx;
      pht_wdata = upd_old;
      if (!run) begin
         pht_we    = 1'b1;
         pht_waddr = ptr_q;
         pht_wdata = CTR_INIT;
      end else if (upd_valid) begin
         pht_we = 1'b1;
         if (upd_taken) begin
            pht_wdata = (upd_old == CTR_MAX) ? upd_old : upd_old + CTR_W'(1);
         end else begin
            pht_wdata = (upd_old == '0) ? upd_old : upd_old - CTR_W'(1);
         end
      end
   end

   // Writes land at the edge, so a same-cycle lookup sees the old counter.
   always_ff @(posedge CLK) begin
      if (pht_we) begin
         pht[pht_waddr] <= pht_wdata;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      ghr_d       = ghr_q;
      stat_pred_d = stat_pred_q;
      stat_miss_d = stat_miss_q;
      unique case (state_q)
         StInit: begin
            ptr_d = ptr_q + IDX_W'(1);
            if (ptr_q == '1) begin
               state_d = StRun;
            end
         end
         StRun: begin
            // Repair wins over the speculative shift of a same-cycle prediction.
            if (repair) begin
               ghr_d = {upd_hist[HIST_W-2:0], upd_taken};
            end else if (pred_valid) begin
               ghr_d = {ghr_q[HIST_W-2:0], pred_taken};
            end
            if (pred_valid && (stat_pred_q != '1)) begin
               stat_pred_d = stat_pred_q + 32'd1;
            end
            if (repair && (stat_miss_q != '1)) begin
               stat_miss_d = stat_miss_q + 32'd1;
            end
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge CLK or posedge RST_X) begin
      if (RST_X) begin
         state_q     <= StInit;
         ptr_q       <= '0;
         ghr_q       <= '0;
         stat_pred_q <= '0;
         stat_miss_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         ghr_q       <= ghr_d;
         stat_pred_q <= stat_pred_d;
         stat_miss_q <= stat_miss_d;
      end
   end

endmodule
